utm_tape_controller: RTL and testbench

- Sequencer for the universal Turing machine datapath.
- Owns the tape storage, head pointer and current-state register, and drives the combinational transition block (state + symbol -> next state, write symbol, move).
- Steps the machine one transition at a time from a start pulse until the halt state or a step limit is reached.
- Provides serial tape loading and random-access tape readback for the pin-limited top level.

---
 rtl/utm_tape_controller.sv | 121 ++++++++++++
 tb/tb_utm_tape_controller.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/utm_tape_controller.sv
// Tape, head and state sequencer for the universal Turing machine datapath.
// Steps the external transition block two clocks per transition until halt or step limit.
module utm_tape_controller #(
    parameter int unsigned TAPE_LEN   = 16,
    parameter int unsigned HEAD_W     = 4,
    parameter logic [7:0]  INIT_STATE = 8'h00,
    parameter logic [7:0]  HALT_STATE = 8'hFF,
    parameter logic [15:0] MAX_STEPS  = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [2:0]        load_sym,
    input  logic              start,
    output logic [7:0]        tf_state,
    output logic [2:0]        tf_sym,
    input  logic [7:0]        tf_next_state,
    input  logic [2:0]        tf_write_sym,
    input  logic [1:0]        tf_move,
    output logic [7:0]        state,
    output logic [HEAD_W-1:0] head,
    output logic              busy,
    output logic              halted,
    output logic              timeout,
    output logic [15:0]       steps,
    input  logic [HEAD_W-1:0] rd_addr,
    output logic [2:0]        rd_sym
);

    typedef enum logic [1:0] {IDLE, FETCH, COMMIT, HALT} fsm_t;

    localparam logic [HEAD_W-1:0] HEAD_ONE = 1;
    localparam logic [15:0]       STEP_ONE = 16'd1;

    fsm_t              fsm;
    logic [2:0]        tape [TAPE_LEN];
    logic [HEAD_W-1:0] load_ptr;
    logic [7:0]        lat_state;
    logic [2:0]        lat_sym;
    logic [1:0]        lat_move;
    logic [HEAD_W-1:0] head_moved;
    logic [15:0]       steps_next;

    assign tf_state   = state;
    assign tf_sym     = tape[head];
    assign rd_sym     = tape[rd_addr];
    assign steps_next = steps + STEP_ONE;

    // Pointer arithmetic relies on HEAD_W-bit wrap for both directions.
    always_comb begin
        head_moved = head;
        case (lat_move)
            2'b01:   head_moved = head + HEAD_ONE;
            2'b10:   head_moved = head - HEAD_ONE;
            default: head_moved = head;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            state     <= INIT_STATE;
            head      <= '0;
            load_ptr  <= '0;
            steps     <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            timeout   <= 1'b0;
            lat_state <= '0;
            lat_sym   <= '0;
            lat_move  <= '0;
            for (int unsigned i = 0; i < TAPE_LEN; i++) tape[i] <= '0;
        end else begin
            case (fsm)
                IDLE, HALT: begin
                    if (start) begin
                        state    <= INIT_STATE;
                        head     <= '0;
                        steps    <= '0;
                        load_ptr <= '0;
                        halted   <= 1'b0;
                        timeout  <= 1'b0;
                        busy     <= 1'b1;
                        fsm      <= FETCH;
                    end else if (load_en) begin
                        tape[load_ptr] <= load_sym;
                        load_ptr       <= load_ptr + HEAD_ONE;
                    end
                end
                FETCH: begin
                    lat_state <= tf_next_state;
                    lat_sym   <= tf_write_sym;
                    lat_move  <= tf_move;
                    fsm       <= COMMIT;
                end
                COMMIT: begin
                    tape[head] <= lat_sym;
                    state      <= lat_state;
                    steps      <= steps_next;
                    if (lat_state == HALT_STATE) begin
                        halted <= 1'b1;
                        busy   <= 1'b0;
                        fsm    <= HALT;
                    end else begin
                        head <= head_moved;
                        if (steps_next == MAX_STEPS) begin
                            halted  <= 1'b1;
                            timeout <= 1'b1;
                            busy    <= 1'b0;
                            fsm     <= HALT;
                        end else begin
                            fsm <= FETCH;
                        end
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_utm_tape_controller.sv
// Scoreboard bench for utm_tape_controller: a table-driven transition block, a
// step-by-step reference machine, and a monitor checking each completed run and tape readback.
`timescale 1ns/100ps
module tb_utm_tape_controller;

    localparam int unsigned TL   = 16;
    localparam int unsigned MAXS = 20;

    typedef logic [TL-1:0][2:0] snap_t;
    typedef struct {
        logic [7:0]  st;
        int unsigned hd;
        int unsigned n;
        bit          to;
        snap_t       tp;
    } run_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [2:0]  load_sym;
    logic        start;
    logic [7:0]  tf_state;
    logic [2:0]  tf_sym;
    logic [7:0]  tf_next_state;
    logic [2:0]  tf_write_sym;
    logic [1:0]  tf_move;
    logic [7:0]  state;
    logic [3:0]  head;
    logic        busy;
    logic        halted;
    logic        timeout;
    logic [15:0] steps;
    logic [3:0]  rd_addr = '0;
    logic [2:0]  rd_sym;

    int unsigned nchecks = 0;
    int unsigned nfails  = 0;

    // Transition program: indexed by {state[4:0], symbol}.
    logic [7:0] tt_next [256];
    logic [2:0] tt_wr   [256];
    logic [1:0] tt_mv   [256];
    logic [7:0] tt_idx;

    snap_t       m_tape;
    int unsigned m_ptr;
    run_t        exp_q [$];
    snap_t       rb_q  [$];

    utm_tape_controller #(
        .TAPE_LEN  (TL),
        .HEAD_W    (4),
        .INIT_STATE(8'h00),
        .HALT_STATE(8'hFF),
        .MAX_STEPS (16'd20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_en      (load_en),
        .load_sym     (load_sym),
        .start        (start),
        .tf_state     (tf_state),
        .tf_sym       (tf_sym),
        .tf_next_state(tf_next_state),
        .tf_write_sym (tf_write_sym),
        .tf_move      (tf_move),
        .state        (state),
        .head         (head),
        .busy         (busy),
        .halted       (halted),
        .timeout      (timeout),
        .steps        (steps),
        .rd_addr      (rd_addr),
        .rd_sym       (rd_sym)
    );

    always #5 clk = ~clk;

    assign tt_idx        = {tf_state[4:0], tf_sym};
    assign tf_next_state = tt_next[tt_idx];
    assign tf_write_sym  = tt_wr[tt_idx];
    assign tf_move       = tt_mv[tt_idx];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_halt_table();
        for (int i = 0; i < 256; i++) begin
            tt_next[i] = 8'hFF; tt_wr[i] = 3'd0; tt_mv[i] = 2'b00;
        end
        tt_next[0] = 8'h00; tt_wr[0] = 3'd1; tt_mv[0] = 2'b01;
        tt_next[1] = 8'hFF; tt_wr[1] = 3'd1; tt_mv[1] = 2'b00;
    endtask

    task automatic set_wrap_table();
        for (int i = 0; i < 256; i++) begin
            tt_next[i] = 8'((i >> 3) + 1); tt_wr[i] = 3'd5; tt_mv[i] = 2'b10;
        end
    endtask

    task automatic set_rand_table();
        for (int i = 0; i < 256; i++) begin
            tt_next[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
            tt_wr[i]   = 3'($urandom_range(0, 7));
            tt_mv[i]   = 2'($urandom_range(0, 3));
        end
    endtask

    // Reference machine: run the program on the model tape, one whole transition per iteration.
    task automatic model_run();
        logic [7:0]  s  = 8'h00;
        int unsigned h  = 0;
        int unsigned n  = 0;
        bit          to = 1'b0;
        logic [7:0]  idx;
        run_t        r;
        for (int k = 0; k < int'(MAXS); k++) begin
            idx = {s[4:0], m_tape[h]};
            n++;
            m_tape[h] = tt_wr[idx];
            s = tt_next[idx];
            if (s == 8'hFF) break;
            if (tt_mv[idx] == 2'b01) h = (h + 1) % TL;
            else if (tt_mv[idx] == 2'b10) h = (h + TL - 1) % TL;
            if (n == MAXS) to = 1'b1;
        end
        r.st = s; r.hd = h; r.n = n; r.to = to; r.tp = m_tape;
        exp_q.push_back(r);
        m_ptr = 0;
    endtask

    task automatic load(input logic [2:0] s);
        load_en = 1'b1; load_sym = s;
        tick();
        load_en = 1'b0;
        m_tape[m_ptr] = s;
        m_ptr = (m_ptr + 1) % TL;
    endtask

    task automatic do_start(input bit with_load, input logic [2:0] s);
        model_run();
        start = 1'b1; load_en = with_load; load_sym = s;
        tick();
        start = 1'b0; load_en = 1'b0;
    endtask

    task automatic settle();
        int unsigned cnt = 0;
        while ((exp_q.size() != 0 || rb_q.size() != 0) && cnt < 200) begin
            tick(); cnt++;
        end
        if (cnt >= 200) check("scoreboard_drain", 32'(exp_q.size() + rb_q.size()), 32'd0);
        tick(); tick();
    endtask

    task automatic wait_idle();
        int unsigned cnt = 0;
        while (busy && cnt < 100) begin
            tick(); cnt++;
        end
        if (busy) check("run_finish_bound", 32'(busy), 32'd0);
        settle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},   32'(state),   32'h00);
        check({tag, "_head"},    32'(head),    32'd0);
        check({tag, "_steps"},   32'(steps),   32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_halted"},  32'(halted),  32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        exp_q.delete();
        m_tape = '0; m_ptr = 0;
        rb_q.push_back('0);
        repeat (3) tick();
        rst_n = 1'b1;
        settle();
    endtask

    // Monitor: run results pop on the busy falling edge; tape snapshots are swept via rd_addr.
    int unsigned busy_cnt = 0;
    bit          prev_busy = 1'b0;
    always @(negedge clk) begin
        run_t  r;
        snap_t sn;
        if (!rst_n) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            else if (prev_busy) begin
                if (exp_q.size() == 0) check("run_unexpected", 32'd1, 32'd0);
                else begin
                    r = exp_q.pop_front();
                    check("run_state",   32'(state),   32'(r.st));
                    check("run_head",    32'(head),    r.hd);
                    check("run_steps",   32'(steps),   r.n);
                    check("run_halted",  32'(halted),  32'd1);
                    check("run_timeout", 32'(timeout), 32'(r.to));
                    check("run_busy_cycles", busy_cnt, 2 * r.n);
                    rb_q.push_back(r.tp);
                end
                busy_cnt = 0;
            end
            prev_busy = busy;
        end
        if (rb_q.size() != 0) begin
            sn = rb_q.pop_front();
            for (int i = 0; i < int'(TL); i++) begin
                rd_addr = 4'(i);
                #0.1;
                check($sformatf("rd_sym[%0d]", i), 32'(rd_sym), 32'(sn[i]));
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; load_en = 1'b0; load_sym = '0; start = 1'b0;
        m_tape = '0; m_ptr = 0;
        set_halt_table();
        repeat (2) tick();
        check_reset_outputs("por");
        rb_q.push_back('0);
        rst_n = 1'b1;
        settle();

        // Load 17 symbols cycling 1..7; the 17th wraps onto cell 0.
        for (int k = 0; k < 17; k++) load(3'((k % 7) + 1));
        rb_q.push_back(m_tape);
        settle();

        // Asynchronous reset in the middle of a load stream.
        for (int k = 0; k < 5; k++) load(3'd7);
        apply_reset("mid_reset");

        // Halting run with start/load pulses ignored while busy.
        for (int k = 0; k < 16; k++) load((k == 3) ? 3'd1 : 3'd0);
        set_halt_table();
        do_start(1'b0, 3'd0);
        tick();
        start = 1'b1; load_en = 1'b1; load_sym = 3'd7;
        tick();
        start = 1'b0; load_en = 1'b0;
        wait_idle();
        check("halt_state", 32'(state), 32'hFF);
        check("halt_steps", 32'(steps), 32'd4);
        check("halt_head",  32'(head),  32'd3);

        // Left moves from head 0 wrap to 15 then 14, and the run times out.
        set_wrap_table();
        do_start(1'b0, 3'd0);
        tick();
        tick();
        check("wrap_head_step1", 32'(head), 32'd15);
        tick();
        tick();
        check("wrap_head_step2", 32'(head), 32'd14);
        wait_idle();
        check("timeout_flag", 32'(timeout), 32'd1);
        do_start(1'b0, 3'd0);
        check("restart_timeout_clear", 32'(timeout), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        wait_idle();

        // start and load_en together in the idle/halt state: the load is dropped.
        for (int k = 0; k < 16; k++) load(3'($urandom_range(0, 7)));
        set_halt_table();
        do_start(1'b1, 3'd7);
        wait_idle();

        // Reset landing while the first step is in COMMIT.
        for (int k = 0; k < 16; k++) load(3'd0);
        set_halt_table();
        do_start(1'b0, 3'd0);
        tick();
        apply_reset("commit_reset");

        // Random programs and tapes.
        for (int it = 0; it < 15; it++) begin
            for (int k = 0; k < 16; k++) load(3'($urandom_range(0, 7)));
            set_rand_table();
            do_start(1'b0, 3'd0);
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfails);
        $finish;
    end

endmodule
